// File: rtl/bidir_bus_ctrl.sv
// rtl/bidir_bus_ctrl.sv - WIDTH-bit bidirectional pad controller with turnaround, input sync and write handshake
//
// Parameters:
//   WIDTH       bus width in bits (>=1)
//   TURN_CYCLES hi-Z cycles inserted on every direction change (>=1)
//   SYNC_STAGES input synchroniser depth (>=1), equal to the RX read latency
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   dir_req  requested direction: 1 = drive bus (TX), 0 = listen (RX)
//   wr_data  value to drive, taken when wr_valid && wr_ready
//   wr_valid wr_data valid
//   wr_ready write accepted (combinational: in TX and dir_req still high)
//   rd_data  last synchroniser stage
//   rd_valid rd_data reflects the bus (RX only, after the flush window)
//   pin      external bus, driven only while oe=1
//   oe       registered output enable
//   busy     turnaround in progress
//   err      sticky contention flag
// Optional feature: define BIDIR_BUS_CONTENTION_EN to enable contention detection
// in TX; otherwise err is tied to 0.

module bidir_bus_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  inout  wire  [WIDTH-1:0] pin,
  output logic             oe,
  output logic             busy,
  output logic             err
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int FW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } state_t;

  state_t           state;
  logic [TW-1:0]    turn_cnt;
  logic [FW-1:0]    flush_cnt;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // oe and the drive value are both registers, so the pad can never be
  // driven and released within the same cycle.
  assign pin      = oe ? out_reg : {WIDTH{1'bz}};
  assign wr_ready = (state == ST_TX) && dir_req;
  assign rd_data  = sync_q[SYNC_STAGES-1];

  // Direction FSM. Turnarounds always run to completion; dir_req is only
  // looked at again once the target state has been reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RX;
      turn_cnt  <= '0;
      flush_cnt <= '0;
      oe        <= 1'b0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      case (state)
        ST_RX: begin
          if (dir_req) begin
            state     <= ST_TURN_TX;
            busy      <= 1'b1;
            turn_cnt  <= '0;
            rd_valid  <= 1'b0;
            flush_cnt <= '0;
          end else if (flush_cnt == FW'(SYNC_STAGES-1)) begin
            // Stale samples from before RX entry have left the chain.
            rd_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        ST_TURN_TX: begin
          if (turn_cnt == TW'(TURN_CYCLES-1)) begin
            state    <= ST_TX;
            busy     <= 1'b0;
            oe       <= 1'b1;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        ST_TX: begin
          if (!dir_req) begin
            state    <= ST_TURN_RX;
            busy     <= 1'b1;
            oe       <= 1'b0;
            turn_cnt <= '0;
          end
        end
        ST_TURN_RX: begin
          if (turn_cnt == TW'(TURN_CYCLES-1)) begin
            state     <= ST_RX;
            busy      <= 1'b0;
            turn_cnt  <= '0;
            flush_cnt <= '0;
            rd_valid  <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: begin
          state     <= ST_RX;
          busy      <= 1'b0;
          oe        <= 1'b0;
          turn_cnt  <= '0;
          flush_cnt <= '0;
          rd_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Output register keeps its value across RX periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
    end else if (wr_valid && wr_ready) begin
      out_reg <= wr_data;
    end
  end

  // Synchroniser samples the pad in every state; rd_valid decides when the
  // result is meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef BIDIR_BUS_CONTENTION_EN
  // The first sync flop holds what was on the pad during the previous
  // cycle, so it is compared against the value driven in that cycle. The
  // first TX cycle is skipped: its sample was taken while still hi-Z.
  logic             tx_run;
  logic [WIDTH-1:0] prev_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_run   <= 1'b0;
      prev_out <= '0;
      err      <= 1'b0;
    end else begin
      prev_out <= out_reg;
      tx_run   <= (state == ST_TX) && dir_req;
      if ((state == ST_TX) && tx_run && (sync_q[0] !== prev_out)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb/tb_bidir_bus_ctrl.sv - randomized self-checking bench for bidir_bus_ctrl against a timestamp model
module tb_bidir_bus_ctrl;

  localparam int W  = 8;
  localparam int TC = 2;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         dir_req;
  logic [W-1:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         oe;
  logic         busy;
  logic         err;
  wire  [W-1:0] pin;

  logic         tb_en;
  logic [W-1:0] tb_val;

  assign pin = tb_en ? tb_val : {W{1'bz}};

  bidir_bus_ctrl #(
    .WIDTH(W),
    .TURN_CYCLES(TC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dir_req(dir_req),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .pin(pin),
    .oe(oe),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: cycle index since reset, settled direction, the cycle at which
  // the current turnaround ends, and the cycle at which RX was entered.
  int           cyc;
  int           turn_end;
  int           rx_since;
  bit           m_dir;
  logic [W-1:0] out_m;
  logic [W-1:0] hist_v [0:4095];
  bit           hist_k [0:4095];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return cyc < turn_end;
  endfunction

  function automatic bit m_oe();
    return !m_busy() && m_dir;
  endfunction

  function automatic bit m_rv();
    return !m_busy() && !m_dir && (cyc >= rx_since + SS);
  endfunction

  function automatic bit next_oe(input bit d);
    if (cyc >= turn_end && d != m_dir) return 1'b0;
    if (cyc + 1 < turn_end) return 1'b0;
    return m_dir;
  endfunction

  task automatic advance(input bit d, input bit v, input logic [W-1:0] wd);
    bit settled;
    settled = (cyc >= turn_end);
    if (m_oe() && d && v) out_m = wd;
    if (settled && d != m_dir) begin
      m_dir    = d;
      turn_end = cyc + 1 + TC;
      if (!d) rx_since = turn_end;
    end
    cyc++;
  endtask

  task automatic check_cycle();
    chk("busy", busy, m_busy());
    chk("oe", oe, m_oe());
    chk("wr_ready", wr_ready, m_oe() && dir_req);
    chk("rd_valid", rd_valid, m_rv());
    if (m_rv() && hist_k[cyc-SS+1]) chk("rd_data", rd_data, hist_v[cyc-SS+1]);
    if (m_oe()) chk("pin_drive", pin, out_m);
    chk("err", err, 0);
  endtask

  // Called at a negedge; applies inputs for the coming edge and checks the
  // cycle that follows it. The bench only drives the pad in cycles where
  // neither this nor the next cycle has the controller driving.
  task automatic step(input bit d, input bit v, input logic [W-1:0] wd, input logic [W-1:0] pv);
    bit cur_oe;
    bit nxt_oe;
    cur_oe   = m_oe();
    nxt_oe   = next_oe(d);
    dir_req  = d;
    wr_valid = v;
    wr_data  = wd;
    if (cur_oe || nxt_oe) begin
      tb_en = 1'b0;
    end else begin
      tb_en  = 1'b1;
      tb_val = pv;
    end
    hist_k[cyc+1] = cur_oe || tb_en;
    hist_v[cyc+1] = cur_oe ? out_m : pv;
    #1;
    chk("wr_ready_now", wr_ready, cur_oe && d);
    @(posedge clk);
    advance(d, v, wd);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset(input bit d);
    rst      = 1'b1;
    dir_req  = d;
    wr_valid = 1'b0;
    tb_en    = 1'b0;
    repeat (2) @(posedge clk);
    cyc      = 0;
    turn_end = 0;
    rx_since = 0;
    m_dir    = 1'b0;
    out_m    = '0;
    @(negedge clk);
    chk("rst_oe", oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
  endtask

  initial begin
    int oe_cnt;
    bit d;
    rst      = 1'b1;
    tb_en    = 1'b0;
    tb_val   = '0;
    dir_req  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;

    do_reset(1'b0);

    // RX read of a fixed pattern
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'hA5);
    chk("rx_data_a5", rd_data, 8'hA5);
    chk("rx_valid", rd_valid, 1);

    // RX -> TX, reset value on the bus, then one write
    repeat (3) step(1'b1, 1'b0, 8'h00, 8'hA5);
    chk("tx_oe", oe, 1);
    chk("tx_reset_out", pin, 8'h00);
    step(1'b1, 1'b1, 8'h3C, 8'h00);
    chk("tx_write_3c", pin, 8'h3C);

    // TX -> RX with a write offered on the dropping edge
    step(1'b0, 1'b1, 8'hFF, 8'h5A);
    repeat (4) step(1'b0, 1'b0, 8'h00, 8'h5A);
    chk("back_rx_valid", rd_valid, 1);

    // direction reverts inside TURN_TX: exactly one TX cycle
    step(1'b1, 1'b0, 8'h00, 8'h11);
    oe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 8'($urandom));
      if (oe) oe_cnt++;
    end
    chk("toggle_oe_cycles", oe_cnt, 1);

`ifdef BIDIR_BUS_CONTENTION_EN
    do_reset(1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 8'h0F, 8'h00);
    force pin = 8'hF0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("contention_err", err, 1);
    release pin;
    dir_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err, 1);
    chk("err_sticky_oe", oe, 0);
    do_reset(1'b0);
`endif

    // randomized traffic with a reset in an arbitrary state part way through
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1'($urandom));
      if ($urandom_range(0, 5) == 0) d = !d;
      step(d, 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
